// File: rtl/lcd_bl_ramp.sv
`timescale 1ns/1ps
// lcd_bl_ramp: fades the backlight level toward a commanded target and drives the PWM period/duty inputs.
// Latency: period/duty follow level by one cycle; backpressure: cmd_ready is low while a ramp is in progress.
module lcd_bl_ramp #(
  parameter int unsigned TICK_DIV    = 1000,
  parameter int unsigned STEP        = 256,
  parameter int unsigned PERIOD_WORD = 1311
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_level,
  input  logic        cmd_fast,
  output logic        busy,
  output logic [15:0] level,
  output logic [15:0] period,
  output logic [15:0] duty
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] UP   = 2'd1;
  localparam logic [1:0] DOWN = 2'd2;

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [15:0] STEP16    = 16'(STEP);
  localparam logic [16:0] STEP17    = 17'(STEP);
  localparam logic [15:0] PERIOD16  = 16'(PERIOD_WORD);

  logic [1:0]  state, state_nxt;
  logic [15:0] target, target_nxt;
  logic [15:0] level_nxt;
  logic [15:0] tick_cnt, tick_cnt_nxt;
  logic [16:0] diff_up, diff_dn;
  logic        accept;
  logic        tick;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign tick      = enable && (state != IDLE) && (tick_cnt == TICK_LAST);
  assign diff_up   = {1'b0, target} - {1'b0, level};
  assign diff_dn   = {1'b0, level} - {1'b0, target};

  always_comb begin
    state_nxt    = state;
    target_nxt   = target;
    level_nxt    = level;
    tick_cnt_nxt = tick_cnt;
    if (accept) begin
      target_nxt   = cmd_level;
      // the acceptance cycle is the first cycle of the first step interval
      tick_cnt_nxt = 16'd1;
      if (cmd_fast || (cmd_level == level)) begin
        level_nxt = cmd_level;
      end else if (cmd_level > level) begin
        state_nxt = UP;
      end else begin
        state_nxt = DOWN;
      end
    end else if (enable && (state != IDLE)) begin
      if (tick) begin
        tick_cnt_nxt = 16'd0;
        if (state == UP) begin
          if (diff_up <= STEP17) begin
            level_nxt = target;
            state_nxt = IDLE;
          end else begin
            level_nxt = level + STEP16;
          end
        end else begin
          if (diff_dn <= STEP17) begin
            level_nxt = target;
            state_nxt = IDLE;
          end else begin
            level_nxt = level - STEP16;
          end
        end
      end else begin
        tick_cnt_nxt = tick_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      target   <= 16'd0;
      level    <= 16'd0;
      tick_cnt <= 16'd0;
      busy     <= 1'b0;
      period   <= 16'd0;
      duty     <= 16'hFFFF;
    end else begin
      state    <= state_nxt;
      target   <= target_nxt;
      level    <= level_nxt;
      tick_cnt <= tick_cnt_nxt;
      busy     <= (state_nxt != IDLE);
      period   <= (enable && (level != 16'd0)) ? PERIOD16 : 16'd0;
      duty     <= (enable && (level != 16'd0)) ? ~level : 16'hFFFF;
    end
  end

endmodule

// File: tb/tb_lcd_bl_ramp.sv
`timescale 1ns/1ps
// Bench for lcd_bl_ramp: arithmetic ramp model checked every cycle, plus directed literal checks.
module tb_lcd_bl_ramp;

  localparam int TICK = 4;
  localparam int STP  = 256;
  localparam int PW   = 1311;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_level = 16'd0;
  logic        cmd_fast = 1'b0;
  logic        busy;
  logic [15:0] level;
  logic [15:0] period;
  logic [15:0] duty;

  int n_cmp = 0;
  int n_bad = 0;
  int t = 0;
  bit done = 1'b0;

  lcd_bl_ramp #(.TICK_DIV(TICK), .STEP(STP), .PERIOD_WORD(PW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_level(cmd_level), .cmd_fast(cmd_fast),
    .busy(busy), .level(level), .period(period), .duty(duty)
  );

  always #5 clk = ~clk;

  // Model: level after k counted cycles since acceptance is start +/- (k/TICK)*STEP, clamped at target.
  logic [15:0] m_level = 16'd0;
  logic [15:0] m_period = 16'd0;
  logic [15:0] m_duty = 16'hFFFF;
  bit          m_busy = 1'b0;
  int          m_start = 0;
  int          m_target = 0;
  int          m_k = 0;
  bit          m_up = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_level = 16'd0; m_period = 16'd0; m_duty = 16'hFFFF;
      m_busy = 1'b0; m_start = 0; m_target = 0; m_k = 0; m_up = 1'b0;
    end else begin
      int v;
      m_period = (enable && m_level != 0) ? 16'(PW) : 16'd0;
      m_duty   = (enable && m_level != 0) ? ~m_level : 16'hFFFF;
      if (!m_busy && cmd_valid) begin
        m_target = int'(cmd_level);
        if (cmd_fast || cmd_level == m_level) begin
          m_level = cmd_level;
        end else begin
          m_start = int'(m_level);
          m_up    = (cmd_level > m_level);
          m_k     = 1;
          m_busy  = 1'b1;
        end
      end else if (m_busy && enable) begin
        m_k++;
        if (m_up) begin
          v = m_start + (m_k / TICK) * STP;
          if (v >= m_target) v = m_target;
        end else begin
          v = m_start - (m_k / TICK) * STP;
          if (v <= m_target) v = m_target;
        end
        m_level = 16'(v);
        if (v == m_target) m_busy = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!done) begin
      chk("cyc_level",  {16'd0, level},  {16'd0, m_level});
      chk("cyc_busy",   {31'd0, busy},   {31'd0, m_busy});
      chk("cyc_ready",  {31'd0, cmd_ready}, {31'd0, !m_busy});
      chk("cyc_period", {16'd0, period}, {16'd0, m_period});
      chk("cyc_duty",   {16'd0, duty},   {16'd0, m_duty});
    end
  end

  task automatic issue(input logic [15:0] lv, input logic f);
    cmd_valid = 1'b1; cmd_level = lv; cmd_fast = f;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_fast = 1'b0;
    t = 1;
  endtask

  task automatic goto(input int n);
    while (t < n) begin
      @(negedge clk);
      t++;
    end
  endtask

  initial begin
    // reset with enable high
    #1 rst_n = 1'b0;
    #2;
    chk("rst_period", {16'd0, period}, 32'h0);
    chk("rst_duty",   {16'd0, duty},   32'hFFFF);
    chk("rst_level",  {16'd0, level},  32'h0);
    chk("rst_busy",   {31'd0, busy},   32'h0);
    chk("rst_ready",  {31'd0, cmd_ready}, 32'h1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_level", {16'd0, level}, 32'h0);
    chk("idle_duty",  {16'd0, duty},  32'hFFFF);

    // ramp up 0 -> 0x0400
    issue(16'h0400, 1'b0);
    chk("up_busy_t1", {31'd0, busy}, 32'h1);
    goto(3);  chk("up_t3",  {16'd0, level}, 32'h0000);
    goto(4);  chk("up_t4",  {16'd0, level}, 32'h0100);
    goto(8);  chk("up_t8",  {16'd0, level}, 32'h0200);
    goto(12); chk("up_t12", {16'd0, level}, 32'h0300);
    goto(16); chk("up_t16", {16'd0, level}, 32'h0400);
    goto(17);
    chk("up_busy_t17",  {31'd0, busy}, 32'h0);
    chk("up_ready_t17", {31'd0, cmd_ready}, 32'h1);
    chk("up_duty",      {16'd0, duty}, 32'hFBFF);
    chk("up_period",    {16'd0, period}, PW);

    // ramp down 0x0400 -> 0x0150, last step is the 0xB0 remainder
    issue(16'h0150, 1'b0);
    goto(4);  chk("dn_t4",  {16'd0, level}, 32'h0300);
    goto(8);  chk("dn_t8",  {16'd0, level}, 32'h0200);
    goto(11); chk("dn_busy_t11", {31'd0, busy}, 32'h1);
    goto(12); chk("dn_t12", {16'd0, level}, 32'h0150);
    goto(13); chk("dn_busy_t13", {31'd0, busy}, 32'h0);

    // fast jump to full, equal command, fast jump to off
    issue(16'hFFFF, 1'b1);
    chk("fast_level", {16'd0, level}, 32'hFFFF);
    chk("fast_busy",  {31'd0, busy},  32'h0);
    goto(2);
    chk("fast_duty",   {16'd0, duty},   32'h0000);
    chk("fast_period", {16'd0, period}, PW);
    issue(16'hFFFF, 1'b0);
    chk("eq_busy", {31'd0, busy}, 32'h0);
    goto(2);
    issue(16'h0000, 1'b1);
    goto(2);
    chk("off_period", {16'd0, period}, 32'h0);
    chk("off_duty",   {16'd0, duty},   32'hFFFF);

    // enable drop for 10 cycles mid-ramp, ignored command while busy
    issue(16'h0400, 1'b0);
    goto(6);  enable = 1'b0;
    goto(7);
    chk("dis_period", {16'd0, period}, 32'h0);
    chk("dis_duty",   {16'd0, duty},   32'hFFFF);
    goto(8);  chk("dis_frozen_t8", {16'd0, level}, 32'h0100);
    goto(10); cmd_valid = 1'b1; cmd_level = 16'h0050; cmd_fast = 1'b1;
    goto(11); cmd_valid = 1'b0; cmd_fast = 1'b0;
    goto(16); chk("dis_frozen_t16", {16'd0, level}, 32'h0100); enable = 1'b1;
    goto(17); chk("en_t17", {16'd0, level}, 32'h0100);
    chk("en_duty_t17", {16'd0, duty}, 32'hFEFF);
    goto(18); chk("en_t18", {16'd0, level}, 32'h0200);
    goto(25); chk("en_t25", {16'd0, level}, 32'h0300);
    goto(26); chk("en_t26", {16'd0, level}, 32'h0400);
    goto(27); chk("en_busy_t27", {31'd0, busy}, 32'h0);

    // async reset mid-ramp at level 0x0200, target 0x0800
    issue(16'h0000, 1'b1);
    goto(2);
    issue(16'h0800, 1'b0);
    goto(8); chk("pre_rst_level", {16'd0, level}, 32'h0200);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_level",  {16'd0, level},  32'h0);
    chk("arst_period", {16'd0, period}, 32'h0);
    chk("arst_duty",   {16'd0, duty},   32'hFFFF);
    chk("arst_busy",   {31'd0, busy},   32'h0);
    chk("arst_ready",  {31'd0, cmd_ready}, 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_level", {16'd0, level}, 32'h0);
    chk("post_rst_ready", {31'd0, cmd_ready}, 32'h1);

    // ramp works again after reset
    issue(16'h0100, 1'b0);
    goto(4); chk("post_rst_t4", {16'd0, level}, 32'h0100);
    goto(8);

    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
